// File: rtl/crank_sync_decoder_pkg.sv
// Shared types and constants for the missing-tooth crank decoder.
package crank_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFirst  = 2'd1,
        StHunt   = 2'd2,
        StSynced = 2'd3
    } crank_state_e;

    // A period is a gap when it is at least prev + (prev >> GapShift), i.e. 1.5x.
    localparam int unsigned GapShift = 1;

    localparam int unsigned DefTeethTotal   = 60;
    localparam int unsigned DefTeethMissing = 2;

endpackage

// File: rtl/crank_sync_decoder_edge_sync.sv
// Two-stage synchronizer followed by a registered rising-edge pulse.
// Generic enough to serve the cam input as well.
module edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic [2:0] pipe;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= '0;
            rise <= 1'b0;
        end else begin
            pipe <= {pipe[1:0], din};
            rise <= pipe[1] & ~pipe[2];
        end
    end

endmodule

// File: rtl/crank_sync_decoder.sv
// Missing-tooth crank decoder: measures tooth periods, finds the gap and
// tracks the tooth index, with sync declare/drop and stall detection.
module crank_sync_decoder
    import crank_pkg::*;
#(
    parameter int unsigned TEETH_TOTAL   = DefTeethTotal,
    parameter int unsigned TEETH_MISSING = DefTeethMissing,
    parameter int unsigned PERIOD_W      = 24,
    parameter int unsigned STALL_CLKS    = 2 ** 23,
    parameter int unsigned IDX_W         = $clog2(TEETH_TOTAL)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                tooth_in,
    output logic                sync,
    output logic [IDX_W-1:0]    tooth_idx,
    output logic                tooth_strobe,
    output logic [PERIOD_W-1:0] tooth_period,
    output logic                sync_loss,
    output logic                stall
);

    localparam logic [IDX_W-1:0]    LastIdx  = IDX_W'(TEETH_TOTAL - TEETH_MISSING - 1);
    localparam logic [PERIOD_W-1:0] StallCnt = PERIOD_W'(STALL_CLKS);

    crank_state_e        state;
    logic                tooth_edge;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] prev;
    logic [PERIOD_W:0]   gap_thresh;
    logic                gap;
    logic                at_last;
    logic                stall_hit;

    edge_sync u_edge_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (tooth_in),
        .rise   (tooth_edge)
    );

    // cnt holds the current period on the edge cycle, so it doubles as cur.
    assign gap_thresh = {1'b0, prev} + {1'b0, prev >> GapShift};
    assign gap        = {1'b0, cnt} >= gap_thresh;
    assign at_last    = tooth_idx == LastIdx;
    assign stall_hit  = !tooth_edge && (cnt == StallCnt) && (state != StIdle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tooth_edge) begin
            cnt <= PERIOD_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            prev         <= '0;
            tooth_period <= '0;
            sync         <= 1'b0;
            tooth_idx    <= '0;
            tooth_strobe <= 1'b0;
            sync_loss    <= 1'b0;
            stall        <= 1'b0;
        end else begin
            tooth_strobe <= 1'b0;
            sync_loss    <= 1'b0;
            stall        <= 1'b0;
            if (tooth_edge) begin
                if (state != StIdle) begin
                    tooth_period <= cnt;
                    prev         <= cnt;
                end
                unique case (state)
                    StIdle:  state <= StFirst;
                    StFirst: state <= StHunt;
                    StHunt: begin
                        if (gap) begin
                            state        <= StSynced;
                            sync         <= 1'b1;
                            tooth_idx    <= '0;
                            tooth_strobe <= 1'b1;
                        end
                    end
                    StSynced: begin
                        if (at_last && gap) begin
                            tooth_idx    <= '0;
                            tooth_strobe <= 1'b1;
                        end else if (!at_last && !gap) begin
                            tooth_idx    <= tooth_idx + IDX_W'(1);
                            tooth_strobe <= 1'b1;
                        end else begin
                            // Gap missing at the last tooth, or arriving early.
                            state     <= StHunt;
                            sync      <= 1'b0;
                            tooth_idx <= '0;
                            sync_loss <= 1'b1;
                        end
                    end
                endcase
            end else if (stall_hit) begin
                stall     <= 1'b1;
                sync_loss <= (state == StSynced);
                state     <= StIdle;
                sync      <= 1'b0;
                tooth_idx <= '0;
            end
        end
    end

endmodule
